// File: rtl/fpu_mul_seq.sv
// Sequential binary16 multiplier: shift-add mantissa product, then normalise.
// Define FPU_MUL_RNE_EN for round-to-nearest-even (default truncates).
module fpu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      state_q;
    logic        sign_q;
    logic [4:0]  ea_q, eb_q;
    logic [10:0] ma_q, mb_q;
    logic [21:0] prod_q;
    logic [3:0]  cnt_q;
    logic [15:0] result_q;
    logic        out_valid_q;

    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        sgn_d, special_d;
    logic [15:0] spec_res_d;

    always_comb begin
        a_nan  = (&op_a[14:10]) && (|op_a[9:0]);
        b_nan  = (&op_b[14:10]) && (|op_b[9:0]);
        a_inf  = (&op_a[14:10]) && !(|op_a[9:0]);
        b_inf  = (&op_b[14:10]) && !(|op_b[9:0]);
        a_zero = (op_a[14:10] == 5'd0);
        b_zero = (op_b[14:10] == 5'd0);
        sgn_d  = op_a[15] ^ op_b[15];
        special_d = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_res_d = 16'h7E00;
        else if (a_inf || b_inf)
            spec_res_d = {sgn_d, 15'h7C00};
        else
            spec_res_d = {sgn_d, 15'h0000};
    end

    logic [21:0]       part_d;
    logic signed [6:0] exp_d;
    logic [9:0]        man_d;
    logic [15:0]       norm_res_d;
`ifdef FPU_MUL_RNE_EN
    logic              guard_d, sticky_d, lsb_d, up_d;
    logic [10:0]       rnd_d;
`endif

    always_comb begin
        part_d = mb_q[0] ? ({11'b0, ma_q} << cnt_q) : 22'b0;
        exp_d  = $signed({2'b0, ea_q}) + $signed({2'b0, eb_q}) - 7'sd15;
        if (prod_q[21]) begin
            man_d = prod_q[20:11];
            exp_d = exp_d + 7'sd1;
        end else begin
            man_d = prod_q[19:10];
        end
`ifdef FPU_MUL_RNE_EN
        guard_d  = prod_q[21] ? prod_q[10] : prod_q[9];
        sticky_d = prod_q[21] ? (|prod_q[9:0]) : (|prod_q[8:0]);
        lsb_d    = man_d[0];
        up_d     = guard_d && (sticky_d || lsb_d);
        rnd_d    = {1'b0, man_d} + {10'b0, up_d};
        man_d    = rnd_d[9:0];
        if (rnd_d[10])
            exp_d = exp_d + 7'sd1;
`endif
        if (exp_d >= 7'sd31)
            norm_res_d = {sign_q, 15'h7C00};
        else if (exp_d <= 7'sd0)
            norm_res_d = {sign_q, 15'h0000};
        else
            norm_res_d = {sign_q, exp_d[4:0], man_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= 5'd0;
            eb_q        <= 5'd0;
            ma_q        <= 11'd0;
            mb_q        <= 11'd0;
            prod_q      <= 22'd0;
            cnt_q       <= 4'd0;
            result_q    <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    sign_q <= sgn_d;
                    ea_q   <= op_a[14:10];
                    eb_q   <= op_b[14:10];
                    ma_q   <= {1'b1, op_a[9:0]};
                    mb_q   <= {1'b1, op_b[9:0]};
                    prod_q <= 22'd0;
                    cnt_q  <= 4'd0;
                    if (special_d) begin
                        result_q <= spec_res_d;
                        state_q  <= DONE;
                    end else begin
                        state_q  <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= prod_q + part_d;
                    mb_q   <= mb_q >> 1;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd10)
                        state_q <= NORM;
                end
                NORM: begin
                    result_q    <= norm_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    // Special results land here one cycle before they are presented.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Scoreboard bench for fpu_mul_seq: directed operands, latency,
// backpressure and mid-operation reset.
module tb_fpu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    fpu_mul_seq dut (
        .clk(clk), .rst_n(rst_n),
        .op_a(op_a), .op_b(op_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic take(input string tag);
        logic [15:0] want;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        want = exp_q.pop_front();
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk(tag, {16'b0, result}, {16'b0, want});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_idle"}, {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic run(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] want,
                       input int want_lat);
        int lat;
        accept(a, b);
        exp_q.push_back(want);
        wait_out(lat);
        if (want_lat >= 0)
            chk({tag, "_lat"}, lat, want_lat);
        take(tag);
    endtask

    initial begin
        int lat;
        logic stable;
        logic [15:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", {16'b0, result}, 32'h0);
        chk("rst_flags", {29'b0, out_valid, busy, in_ready}, 32'd1);
        rst_n = 1'b1;

        run("one_x_one", 16'h3C00, 16'h3C00, 16'h3C00, 12);
        run("1p5_sq", 16'h3E00, 16'h3E00, 16'h4080, 12);
        run("neg_x_two", 16'hBC00, 16'h4000, 16'hC000, 12);
        run("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 1);
        run("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00, 12);
`ifdef FPU_MUL_RNE_EN
        run("round", 16'h3E01, 16'h3C01, 16'h3E03, 12);
`else
        run("round", 16'h3E01, 16'h3C01, 16'h3E02, 12);
`endif
        run("nan_x_one", 16'h7E01, 16'h3C00, 16'h7E00, 1);
        run("inf_x_neg2", 16'h7C00, 16'hC000, 16'hFC00, 1);
        run("subn_flush", 16'h8001, 16'h3C00, 16'h8000, 1);
        run("underflow", 16'h0400, 16'h0400, 16'h0000, 12);
        run("three_x_3", 16'h4200, 16'h4200, 16'h4880, 12);
        run("half_x_neg", 16'h3800, 16'hC400, 16'hC000, 12);

        // Backpressure: hold the consumer off with a new request pending.
        accept(16'h4000, 16'h4200);
        exp_q.push_back(16'h4600);
        wait_out(lat);
        chk("bp_lat", lat, 12);
        held = result;
        stable = 1'b1;
        op_a = 16'h3C00;
        op_b = 16'h3C00;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || result !== held)
                stable = 1'b0;
        end
        chk("bp_stable", {31'b0, stable}, 32'd1);
        in_valid = 1'b0;
        take("bp_result");
        @(posedge clk);
        #1 chk("bp_no_extra", {31'b0, busy}, 32'd0);

        // Reset in the middle of MUL discards the operation.
        accept(16'h4000, 16'h4000);
        repeat (5) @(posedge clk);
        #1 chk("mid_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_result", {16'b0, result}, 32'h0);
        chk("mrst_flags", {29'b0, out_valid, busy, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1 chk("mrst_no_out", {31'b0, out_valid}, 32'd0);

        run("after_rst", 16'h4000, 16'h4000, 16'h4400, 12);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1);
    end

endmodule
